// File: rtl/eth_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_parser_if
// Function : 32-bit MSB-first receive stream (data/valid/last/keep/ready).
// Revision : 1.0  initial release
// ============================================================================
interface eth_frame_parser_if;
  logic [31:0] i_rx_data;
  logic        i_rx_tvalid;
  logic        i_rx_tlast;
  logic [3:0]  i_rx_tkeep;
  logic        o_rx_tready;

  modport master (
    output i_rx_data,
    output i_rx_tvalid,
    output i_rx_tlast,
    output i_rx_tkeep,
    input  o_rx_tready
  );

  modport slave (
    input  i_rx_data,
    input  i_rx_tvalid,
    input  i_rx_tlast,
    input  i_rx_tkeep,
    output o_rx_tready
  );
endinterface
`default_nettype wire

// File: rtl/eth_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_parser
// Function : Ethernet frame parser: header capture, byte count, runt/giant flags.
// Option   : define ETH_PAYLOAD_CHECK_EN to check payload byte k against k mod 256.
// Revision : 1.0  initial release
// ============================================================================
module eth_frame_parser #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 1514
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  eth_frame_parser_if.slave  rx_if,
  output logic [47:0]        o_dest_mac,
  output logic [47:0]        o_src_mac,
  output logic [15:0]        o_ether_type,
  output logic               o_hdr_valid,
  output logic [15:0]        o_frame_len,
  output logic               o_frame_done,
  output logic               o_runt,
  output logic               o_giant,
  output logic               o_payload_err
);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [15:0] c_min_len = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] c_max_len = 16'(MAX_FRAME_BYTES);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [47:0] dest_sh_q, dest_sh_d;
  logic [47:0] src_sh_q, src_sh_d;
  logic [47:0] dest_q, dest_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [15:0] len_q, len_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        done_q, done_d;
  logic        runt_q, runt_d;
  logic        giant_q, giant_d;

  logic        w_xfer;
  logic [2:0]  w_beat_bytes;
  logic [16:0] w_sum;
  logic [15:0] w_cnt_next;
  logic        w_hdr_ok;

  assign rx_if.o_rx_tready = (state_q != S_DONE);
  assign w_xfer            = rx_if.i_rx_tvalid && rx_if.o_rx_tready;

  // Last beat contributes the leading-ones count of tkeep; odd masks count as full.
  always_comb begin
    w_beat_bytes = 3'd4;
    if (rx_if.i_rx_tlast) begin
      case (rx_if.i_rx_tkeep)
        4'b1110: w_beat_bytes = 3'd3;
        4'b1100: w_beat_bytes = 3'd2;
        4'b1000: w_beat_bytes = 3'd1;
        default: w_beat_bytes = 3'd4;
      endcase
    end
  end

  assign w_sum      = {1'b0, cnt_q} + {14'd0, w_beat_bytes};
  assign w_cnt_next = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign w_hdr_ok   = !rx_if.i_rx_tlast || (rx_if.i_rx_tkeep >= 4'b1100);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dest_sh_d   = dest_sh_q;
    src_sh_d    = src_sh_q;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    len_d       = len_q;
    runt_d      = runt_q;
    giant_d     = giant_q;
    hdr_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_HDR: begin
        if (w_xfer) begin
          cnt_d = w_cnt_next;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: dest_sh_d[47:16] = rx_if.i_rx_data;
            2'd1: begin
              dest_sh_d[15:0]  = rx_if.i_rx_data[31:16];
              src_sh_d[47:32]  = rx_if.i_rx_data[15:0];
            end
            2'd2: src_sh_d[31:0] = rx_if.i_rx_data;
            default: begin
              // Visible fields change only when a complete header is committed.
              if (w_hdr_ok) begin
                dest_d      = dest_sh_q;
                src_d       = src_sh_q;
                type_d      = rx_if.i_rx_data[31:16];
                hdr_valid_d = 1'b1;
              end
              state_d = S_PAYLOAD;
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (w_xfer) begin
          cnt_d = w_cnt_next;
        end
      end
      default: begin
        state_d = S_HDR;
        idx_d   = 2'd0;
      end
    endcase

    if (w_xfer && rx_if.i_rx_tlast) begin
      state_d = S_DONE;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
      done_d  = 1'b1;
      len_d   = w_cnt_next;
      runt_d  = (w_cnt_next < c_min_len);
      giant_d = (w_cnt_next > c_max_len);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      idx_q       <= 2'd0;
      cnt_q       <= 16'd0;
      dest_sh_q   <= 48'd0;
      src_sh_q    <= 48'd0;
      dest_q      <= 48'd0;
      src_q       <= 48'd0;
      type_q      <= 16'd0;
      len_q       <= 16'd0;
      runt_q      <= 1'b0;
      giant_q     <= 1'b0;
      hdr_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dest_sh_q   <= dest_sh_d;
      src_sh_q    <= src_sh_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      len_q       <= len_d;
      runt_q      <= runt_d;
      giant_q     <= giant_d;
      hdr_valid_q <= hdr_valid_d;
      done_q      <= done_d;
    end
  end

  assign o_dest_mac   = dest_q;
  assign o_src_mac    = src_q;
  assign o_ether_type = type_q;
  assign o_hdr_valid  = hdr_valid_q;
  assign o_frame_len  = len_q;
  assign o_frame_done = done_q;
  assign o_runt       = runt_q;
  assign o_giant      = giant_q;

`ifdef ETH_PAYLOAD_CHECK_EN
  logic [7:0] pl_idx_q, pl_idx_d;
  logic       err_acc_q, err_acc_d;
  logic       perr_q, perr_d;
  logic [3:0] w_mask;
  logic       w_beat_err;

  assign w_mask = rx_if.i_rx_tlast ? rx_if.i_rx_tkeep : 4'hF;

  // Payload starts in the low half of header word 3, so that beat checks two bytes.
  always_comb begin
    w_beat_err = 1'b0;
    if (state_q == S_HDR && idx_q == 2'd3) begin
      w_beat_err = (w_mask[1] && (rx_if.i_rx_data[15:8] != pl_idx_q)) ||
                   (w_mask[0] && (rx_if.i_rx_data[7:0]  != pl_idx_q + 8'd1));
    end else if (state_q == S_PAYLOAD) begin
      w_beat_err = (w_mask[3] && (rx_if.i_rx_data[31:24] != pl_idx_q)) ||
                   (w_mask[2] && (rx_if.i_rx_data[23:16] != pl_idx_q + 8'd1)) ||
                   (w_mask[1] && (rx_if.i_rx_data[15:8]  != pl_idx_q + 8'd2)) ||
                   (w_mask[0] && (rx_if.i_rx_data[7:0]   != pl_idx_q + 8'd3));
    end
  end

  always_comb begin
    pl_idx_d  = pl_idx_q;
    err_acc_d = err_acc_q;
    perr_d    = perr_q;
    if (w_xfer) begin
      if (state_q == S_HDR && idx_q == 2'd3) begin
        pl_idx_d = pl_idx_q + 8'd2;
      end else if (state_q == S_PAYLOAD) begin
        pl_idx_d = pl_idx_q + 8'd4;
      end
      err_acc_d = err_acc_q | w_beat_err;
      if (rx_if.i_rx_tlast) begin
        perr_d    = err_acc_q | w_beat_err;
        err_acc_d = 1'b0;
        pl_idx_d  = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pl_idx_q  <= 8'd0;
      err_acc_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      pl_idx_q  <= pl_idx_d;
      err_acc_q <= err_acc_d;
      perr_q    <= perr_d;
    end
  end

  assign o_payload_err = perr_q;
`else
  assign o_payload_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_frame_parser
// Function : Directed self-checking bench for eth_frame_parser.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_frame_parser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eth_frame_parser_if rx_if();

  logic [47:0] dest_mac, src_mac;
  logic [15:0] ether_type, frame_len;
  logic        hdr_valid, frame_done, runt, giant, payload_err;

  eth_frame_parser #(
    .MIN_FRAME_BYTES (60),
    .MAX_FRAME_BYTES (1514)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_if         (rx_if),
    .o_dest_mac    (dest_mac),
    .o_src_mac     (src_mac),
    .o_ether_type  (ether_type),
    .o_hdr_valid   (hdr_valid),
    .o_frame_len   (frame_len),
    .o_frame_done  (frame_done),
    .o_runt        (runt),
    .o_giant       (giant),
    .o_payload_err (payload_err)
  );

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int hv_cnt   = 0;

  logic [47:0] g_dest, g_src, e_dest, e_src;
  logic [15:0] g_type, e_type;

  always @(posedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (hdr_valid)  hv_cnt   <= hv_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input int i, input int corrupt);
    int k;
    if (i < 6)  return g_dest[(47 - 8*i) -: 8];
    if (i < 12) return g_src[(47 - 8*(i-6)) -: 8];
    if (i < 14) return g_type[(15 - 8*(i-12)) -: 8];
    k = i - 14;
    return (k == corrupt) ? ~k[7:0] : k[7:0];
  endfunction

  function automatic logic [31:0] fword(input int w, input int corrupt);
    return {fbyte(4*w, corrupt), fbyte(4*w+1, corrupt),
            fbyte(4*w+2, corrupt), fbyte(4*w+3, corrupt)};
  endfunction

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [31:0] d, input logic l, input logic [3:0] k);
    int t;
    t = 0;
    rx_if.i_rx_data   = d;
    rx_if.i_rx_tlast  = l;
    rx_if.i_rx_tkeep  = k;
    rx_if.i_rx_tvalid = 1'b1;
    while (!rx_if.o_rx_tready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("tready_timeout", {63'd0, rx_if.o_rx_tready}, 64'd1);
    @(negedge clk);
    rx_if.i_rx_tvalid = 1'b0;
    rx_if.i_rx_tlast  = 1'b0;
  endtask

  task automatic send_frame(input string tag, input int nw, input logic [3:0] lk,
                            input bit gaps, input int corrupt, input logic exp_hv,
                            input logic [15:0] exp_len, input logic exp_runt,
                            input logic exp_giant, input logic exp_perr);
    int hv0;
    hv0 = hv_cnt;
    for (int w = 0; w < nw; w++) begin
      send(fword(w, corrupt), (w == nw-1), (w == nw-1) ? lk : 4'hF);
      if (w == 3) chk({tag, "_hdr_valid"}, {63'd0, hdr_valid}, {63'd0, exp_hv});
      if (gaps && (w % 10) == 9 && w != nw-1) repeat (2) @(negedge clk);
    end
    chk({tag, "_done"},   {63'd0, frame_done},        64'd1);
    chk({tag, "_tready"}, {63'd0, rx_if.o_rx_tready}, 64'd0);
    chk({tag, "_len"},    {48'd0, frame_len},          {48'd0, exp_len});
    chk({tag, "_runt"},   {63'd0, runt},               {63'd0, exp_runt});
    chk({tag, "_giant"},  {63'd0, giant},              {63'd0, exp_giant});
    chk({tag, "_perr"},   {63'd0, payload_err},        {63'd0, exp_perr});
    @(negedge clk);
    chk({tag, "_done_end"},   {63'd0, frame_done},        64'd0);
    chk({tag, "_tready_end"}, {63'd0, rx_if.o_rx_tready}, 64'd1);
    chk({tag, "_len_hold"},   {48'd0, frame_len},          {48'd0, exp_len});
    chk({tag, "_hv_count"},   64'(hv_cnt - hv0),           {63'd0, exp_hv});
    if (exp_hv) begin
      e_dest = g_dest;
      e_src  = g_src;
      e_type = g_type;
    end
    chk({tag, "_dest"}, {16'd0, dest_mac},   {16'd0, e_dest});
    chk({tag, "_src"},  {16'd0, src_mac},    {16'd0, e_src});
    chk({tag, "_type"}, {48'd0, ether_type}, {48'd0, e_type});
  endtask

  initial begin
    int done0;
    g_dest = 48'h0014_2201_2345;
    g_src  = 48'h0014_2267_89AB;
    g_type = 16'h0800;
    e_dest = 48'd0;
    e_src  = 48'd0;
    e_type = 16'd0;
    rx_if.i_rx_data   = 32'd0;
    rx_if.i_rx_tvalid = 1'b0;
    rx_if.i_rx_tlast  = 1'b0;
    rx_if.i_rx_tkeep  = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_tready", {63'd0, rx_if.o_rx_tready}, 64'd1);
    chk("rst_dest",   {16'd0, dest_mac},          64'd0);
    chk("rst_src",    {16'd0, src_mac},           64'd0);
    chk("rst_type",   {48'd0, ether_type},        64'd0);
    chk("rst_len",    {48'd0, frame_len},         64'd0);
    chk("rst_flags",  {59'd0, hdr_valid, frame_done, runt, giant, payload_err}, 64'd0);

    send_frame("full1514", 379, 4'b1100, 1'b0, -1, 1'b1, 16'h05EA, 1'b0, 1'b0, 1'b0);
    send_frame("gaps1514", 379, 4'b1100, 1'b1, -1, 1'b1, 16'h05EA, 1'b0, 1'b0, 1'b0);

    // Truncated header with a different dest: visible header must hold.
    g_dest = 48'hFFFF_FFFF_FFFF;
    send_frame("trunc3",   3,   4'b1111, 1'b0, -1, 1'b0, 16'd12,   1'b1, 1'b0, 1'b0);
    g_dest = 48'h0014_2201_2345;

    send_frame("giant1520", 380, 4'b1111, 1'b0, -1, 1'b1, 16'd1520, 1'b0, 1'b1, 1'b0);
    send_frame("giant1515", 379, 4'b1110, 1'b0, -1, 1'b1, 16'd1515, 1'b0, 1'b1, 1'b0);
    send_frame("min60",     15,  4'b1111, 1'b0, -1, 1'b1, 16'd60,   1'b0, 1'b0, 1'b0);
    send_frame("runt59",    15,  4'b1110, 1'b0, -1, 1'b1, 16'd59,   1'b1, 1'b0, 1'b0);
    send_frame("len61",     16,  4'b1000, 1'b0, -1, 1'b1, 16'd61,   1'b0, 1'b0, 1'b0);
    send_frame("oddkeep",   15,  4'b1010, 1'b0, -1, 1'b1, 16'd60,   1'b0, 1'b0, 1'b0);
    send_frame("w3k1100",   4,   4'b1100, 1'b0, -1, 1'b1, 16'd14,   1'b1, 1'b0, 1'b0);
    g_src = 48'h1111_2222_3333;
    send_frame("w3k1000",   4,   4'b1000, 1'b0, -1, 1'b0, 16'd13,   1'b1, 1'b0, 1'b0);
    g_src = 48'h0014_2267_89AB;
    send_frame("saturate",  16400, 4'b1111, 1'b0, -1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);

    // Reset partway through a frame: partial frame leaves no trace.
    for (int w = 0; w < 50; w++) send(fword(w, -1), 1'b0, 4'hF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_done",   {63'd0, frame_done},        64'd0);
    chk("midrst_tready", {63'd0, rx_if.o_rx_tready}, 64'd1);
    chk("midrst_dest",   {16'd0, dest_mac},          64'd0);
    chk("midrst_len",    {48'd0, frame_len},         64'd0);
    e_dest = 48'd0;
    e_src  = 48'd0;
    e_type = 16'd0;
    done0 = done_cnt;
    send_frame("after_rst", 379, 4'b1100, 1'b0, -1, 1'b1, 16'h05EA, 1'b0, 1'b0, 1'b0);
    chk("midrst_done_count", 64'(done_cnt - done0), 64'd1);

`ifdef ETH_PAYLOAD_CHECK_EN
    send_frame("corrupt100", 379, 4'b1100, 1'b0, 100, 1'b1, 16'h05EA, 1'b0, 1'b0, 1'b1);
    send_frame("clean",      379, 4'b1100, 1'b0, -1,  1'b1, 16'h05EA, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
